// File: rtl/ram2_test_ctrl_if.sv
// ram2_test_ctrl_if: fetch/data request side and RAM2 pin side of the shared SRAM port.
interface ram2_test_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int IN_W   = 3
);
    logic [IN_W-1:0]   pc;
    logic [IN_W-1:0]   m_data;
    logic [IN_W-1:0]   m_addr;
    logic              m_re;
    logic              m_we;
    logic              m_ce;
    logic [1:0]        state_o;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_re;
    logic              mem_ce;
    logic              mem_we;

    modport master (
        output pc, m_data, m_addr, m_re, m_we, m_ce,
        input  state_o, pc_addr, mem_addr, mem_data_i, mem_re, mem_ce, mem_we
    );

    modport slave (
        input  pc, m_data, m_addr, m_re, m_we, m_ce,
        output state_o, pc_addr, mem_addr, mem_data_i, mem_re, mem_ce, mem_we
    );
endinterface

// File: rtl/ram2_test_ctrl.sv
// ram2_test_ctrl: time-multiplexes one RAM2 port between instruction fetch and data access.
// Optional write-recovery gap state S_WAIT enabled by defining RAM2_WE_GAP_EN.
module ram2_test_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int IN_W   = 3
) (
    input logic             clk,
    input logic             rst,
    ram2_test_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_MEM   = 2'b10,
        S_WAIT  = 2'b11
    } state_t;

    state_t            state_q, state_d, mem_next, wait_next;
    logic [ADDR_W-1:0] pc_addr_q, pc_addr_d, hold_addr, pc_ext, m_addr_ext;
    logic              is_fetch, is_mem, wr;

    assign pc_ext     = {{(ADDR_W-IN_W){1'b0}}, bus.pc};
    assign m_addr_ext = {{(ADDR_W-IN_W){1'b0}}, bus.m_addr};
    assign is_fetch   = state_q == S_FETCH;
    assign is_mem     = state_q == S_MEM;
    assign wr         = is_mem && !bus.m_we;

`ifdef RAM2_WE_GAP_EN
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    always_comb begin
        last_addr_d = is_mem ? m_addr_ext : last_addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_addr_q <= '0;
        else      last_addr_q <= last_addr_d;
    end

    assign hold_addr = (state_q == S_WAIT) ? last_addr_q : '0;
    assign mem_next  = wr ? S_WAIT : S_FETCH;
    assign wait_next = S_FETCH;
`else
    // 2'b11 is unreachable here; recover through S_IDLE if it ever appears
    assign hold_addr = '0;
    assign mem_next  = S_FETCH;
    assign wait_next = S_IDLE;
`endif

    always_comb begin
        state_d   = is_fetch ? (bus.m_ce ? S_FETCH : S_MEM)
                  : is_mem ? mem_next
                  : (state_q == S_IDLE) ? S_FETCH : wait_next;
        pc_addr_d = is_fetch ? pc_ext : pc_addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_addr_q <= pc_addr_d;
        end
    end

    // Pin decode is combinational so the bus is valid in the cycle the state is entered
    assign bus.state_o    = state_q;
    assign bus.pc_addr    = pc_addr_q;
    assign bus.mem_ce     = !(is_fetch || is_mem);
    assign bus.mem_we     = !wr;
    assign bus.mem_re     = is_fetch ? 1'b0 : is_mem ? (wr || bus.m_re) : 1'b1;
    assign bus.mem_addr   = is_fetch ? pc_ext : is_mem ? m_addr_ext : hold_addr;
    assign bus.mem_data_i = wr ? {{(DATA_W-IN_W){1'b0}}, bus.m_data} : '0;
endmodule

// File: tb/tb_ram2_test_ctrl.sv
// tb_ram2_test_ctrl: directed stimulus with a queue scoreboard checked on the falling edge.
module tb_ram2_test_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [15:0] pca;
        logic [15:0] addr;
        logic [15:0] data;
        logic        re;
        logic        ce;
        logic        we;
    } exp_t;

    exp_t exp_q[$];

    ram2_test_ctrl_if bus ();

    ram2_test_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Each step drives just after a rising edge and queues what the next falling edge must show
    task automatic step(input string n, input logic r, input logic [2:0] p, input logic [2:0] md,
                        input logic [2:0] ma, input logic re_i, input logic we_i, input logic ce_i,
                        input logic [1:0] st, input logic [15:0] pca, input logic [15:0] addr,
                        input logic [15:0] data, input logic ere, input logic ece, input logic ewe);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus.pc = p;
        bus.m_data = md;
        bus.m_addr = ma;
        bus.m_re = re_i;
        bus.m_we = we_i;
        bus.m_ce = ce_i;
        e.name = n;
        e.st = st;
        e.pca = pca;
        e.addr = addr;
        e.data = data;
        e.re = ere;
        e.ce = ece;
        e.we = ewe;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if (bus.state_o !== e.st || bus.pc_addr !== e.pca || bus.mem_addr !== e.addr ||
                    bus.mem_data_i !== e.data || bus.mem_re !== e.re || bus.mem_ce !== e.ce ||
                    bus.mem_we !== e.we) begin
                    mismatched++;
                    $display("FAIL %s: got st=%0d pc_addr=%h addr=%h data=%h re=%b ce=%b we=%b, need st=%0d pc_addr=%h addr=%h data=%h re=%b ce=%b we=%b",
                             e.name, bus.state_o, bus.pc_addr, bus.mem_addr, bus.mem_data_i,
                             bus.mem_re, bus.mem_ce, bus.mem_we,
                             e.st, e.pca, e.addr, e.data, e.re, e.ce, e.we);
                end
            end
        end
    end

    initial begin
        bus.pc = 3'd1;
        bus.m_data = 3'd0;
        bus.m_addr = 3'd0;
        bus.m_re = 1'b1;
        bus.m_we = 1'b1;
        bus.m_ce = 1'b1;
        //     name        rst pc md ma re we ce   st  pc_addr  addr     data     re ce we
        step("reset",      0, 1, 0, 0, 1, 1, 1,  0, 16'h0, 16'h0, 16'h0, 1, 1, 1);
        step("release",    1, 1, 0, 0, 1, 1, 1,  0, 16'h0, 16'h0, 16'h0, 1, 1, 1);
        step("fetch1",     1, 1, 0, 0, 1, 1, 1,  1, 16'h0, 16'h1, 16'h0, 0, 0, 1);
        step("fetch1_pc",  1, 1, 0, 0, 1, 1, 1,  1, 16'h1, 16'h1, 16'h0, 0, 0, 1);
        step("wr_inputs",  1, 2, 3, 3, 1, 0, 0,  1, 16'h1, 16'h2, 16'h0, 0, 0, 1);
        step("wr_mem",     1, 2, 3, 3, 1, 0, 0,  2, 16'h2, 16'h3, 16'h3, 1, 0, 0);
`ifdef RAM2_WE_GAP_EN
        step("wr_gap",     1, 2, 3, 3, 1, 0, 0,  3, 16'h2, 16'h3, 16'h0, 1, 1, 1);
`endif
        step("rd_fetch",   1, 2, 3, 4, 0, 1, 0,  1, 16'h2, 16'h2, 16'h0, 0, 0, 1);
        step("rd_mem",     1, 2, 3, 4, 0, 1, 0,  2, 16'h2, 16'h4, 16'h0, 0, 0, 1);
        step("idle_fetch", 1, 2, 3, 4, 1, 1, 1,  1, 16'h2, 16'h2, 16'h0, 0, 0, 1);
        step("idle_stay",  1, 2, 6, 5, 0, 0, 0,  1, 16'h2, 16'h2, 16'h0, 0, 0, 1);
        step("conflict",   1, 2, 6, 5, 0, 0, 0,  2, 16'h2, 16'h5, 16'h6, 1, 0, 0);
`ifdef RAM2_WE_GAP_EN
        step("cf_gap",     1, 2, 6, 5, 0, 0, 0,  3, 16'h2, 16'h5, 16'h0, 1, 1, 1);
`endif
        step("wd_fetch",   1, 2, 0, 7, 0, 1, 0,  1, 16'h2, 16'h2, 16'h0, 0, 0, 1);
        step("withdraw",   1, 2, 0, 7, 0, 1, 1,  2, 16'h2, 16'h7, 16'h0, 0, 0, 1);
        step("pre_rst",    1, 4, 5, 6, 1, 0, 0,  1, 16'h2, 16'h4, 16'h0, 0, 0, 1);
        step("async_rst",  0, 4, 5, 6, 1, 0, 0,  0, 16'h0, 16'h0, 16'h0, 1, 1, 1);
        step("rel2",       1, 4, 5, 6, 1, 1, 1,  0, 16'h0, 16'h0, 16'h0, 1, 1, 1);
        step("refetch",    1, 4, 5, 6, 1, 1, 1,  1, 16'h0, 16'h4, 16'h0, 0, 0, 1);
        step("refetch_pc", 1, 4, 5, 6, 1, 1, 1,  1, 16'h4, 16'h4, 16'h0, 0, 0, 1);
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
